// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory req/ack port between the CPU controller and a DMA/loader
//   requester. Each requester runs a single-outstanding req/done handshake.
//   CPU has priority; after CPU_BURST back-to-back CPU grants while DMA is
//   waiting, DMA gets the next grant.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     When defined, a BUSY access that sees no mem_ack for TIMEOUT cycles is
//     aborted. The owner's done pulses together with err. A timed-out read
//     returns all-ones. Without the macro, BUSY waits forever and err is 0.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_done, cpu_rdata    CPU requester
//   dma_req/we/addr/wdata -> dma_done, dma_rdata    DMA requester
//   mem_req/we/addr/wdata <- mem_ack, mem_rdata     memory port
//   err                               one-cycle timeout abort pulse
module mem_port_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int CPU_BURST = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  if (CPU_BURST < 1 || CPU_BURST > 15) begin : g_bad_burst
    $error("mem_port_arbiter: CPU_BURST out of range 1..15");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT out of range 2..255");
  end

  localparam logic [3:0] BURST = 4'(CPU_BURST);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t     state, state_nx;
  logic       owner;      // 0 = CPU, 1 = DMA
  logic [3:0] streak;     // consecutive CPU grants taken while DMA waited
  logic       grant_dma;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       to_flag;    // current RESP is a timeout abort
  logic       to_hit;
`endif

  // next state and outputs
  always_comb begin
    state_nx  = state;
    // DMA wins when alone, or when the CPU has used up its burst allowance
    grant_dma = dma_req && (!cpu_req || streak == BURST);
`ifdef ARB_TIMEOUT_EN
    to_hit    = 1'b0;
`endif
    case (state)
      IDLE: if (cpu_req || dma_req) state_nx = BUSY;
      BUSY: begin
        if (mem_ack) state_nx = RESP;
`ifdef ARB_TIMEOUT_EN
        // a late ack on the expiry cycle still completes normally
        else if (tcnt == 8'(TIMEOUT - 1)) begin
          state_nx = RESP;
          to_hit   = 1'b1;
        end
`endif
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    mem_req  = (state == BUSY);
    cpu_done = (state == RESP) && !owner;
    dma_done = (state == RESP) &&  owner;
`ifdef ARB_TIMEOUT_EN
    err      = (state == RESP) && to_flag;
`else
    err      = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      streak    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
      tcnt      <= '0;
      to_flag   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner <= grant_dma;
            if (grant_dma) begin
              mem_we    <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
              streak    <= '0;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              // only counts while DMA is actually being held off; the grant
              // rule above keeps this from passing BURST
              streak    <= dma_req ? 4'(streak + 4'd1) : 4'd0;
            end
          end
`ifdef ARB_TIMEOUT_EN
          tcnt    <= '0;
          to_flag <= 1'b0;
`endif
        end
        BUSY: begin
          if (mem_ack) begin
            if (!mem_we) begin
              if (owner) dma_rdata <= mem_rdata;
              else       cpu_rdata <= mem_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (to_hit) begin
            to_flag <= 1'b1;
            if (!mem_we) begin
              if (owner) dma_rdata <= '1;
              else       cpu_rdata <= '1;
            end
          end else begin
            tcnt <= 8'(tcnt + 8'd1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, mem_ack;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_done, dma_done, mem_req, mem_we, err;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.AW(16), .DW(16), .CPU_BURST(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Serve one memory access with an immediate ack; who = {dma_done, cpu_done}
  // seen in the response cycle. Returns in IDLE.
  task automatic serve(input logic [15:0] rdata, output logic [1:0] who);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    if (!mem_req) check("serve_wait_mem_req", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ack = 1'b0;
    who = {dma_done, cpu_done};
    tick();
  endtask

  localparam logic [1:0] C = 2'b01;
  localparam logic [1:0] D = 2'b10;

  initial begin
    logic [1:0] who;
    logic [1:0] burst_seq [10];
    int cnt;
    burst_seq = '{C, C, C, C, D, C, C, C, C, D};

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    tick(); tick();

    // reset state
    check("rst_mem_req",   32'(mem_req),   0);
    check("rst_mem_we",    32'(mem_we),    0);
    check("rst_mem_addr",  32'(mem_addr),  0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_cpu_done",  32'(cpu_done),  0);
    check("rst_dma_done",  32'(dma_done),  0);
    check("rst_err",       32'(err),       0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_dma_rdata", 32'(dma_rdata), 0);
    rst = 1'b0;
    tick();

    // CPU read, ack in first mem_req cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick();
    check("rd_mem_req",  32'(mem_req),  1);
    check("rd_mem_addr", 32'(mem_addr), 32'h0010);
    check("rd_mem_we",   32'(mem_we),   0);
    check("rd_done_early", 32'(cpu_done), 0);
    mem_ack = 1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 0; mem_rdata = 16'h0000;
    check("rd_mem_req_drop", 32'(mem_req),   0);
    check("rd_cpu_done",     32'(cpu_done),  1);
    check("rd_dma_done",     32'(dma_done),  0);
    check("rd_cpu_rdata",    32'(cpu_rdata), 32'hBEEF);
    cpu_req = 0;
    tick();
    check("rd_done_once",  32'(cpu_done),  0);
    check("rd_rdata_hold", 32'(cpu_rdata), 32'hBEEF);

    // DMA write, ack on fourth mem_req cycle
    dma_req = 1; dma_we = 1; dma_addr = 16'h0200; dma_wdata = 16'h1234;
    tick();
    check("wr_mem_addr",  32'(mem_addr),  32'h0200);
    check("wr_mem_we",    32'(mem_we),    1);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h1234);
    cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      if (mem_req && !dma_done) cnt++;
      if (k == 4) begin mem_ack = 1; mem_rdata = 16'hDEAD; end
      tick();
    end
    mem_ack = 0;
    check("wr_req_cycles",  32'(cnt),       4);
    check("wr_dma_done",    32'(dma_done),  1);
    check("wr_cpu_done",    32'(cpu_done),  0);
    check("wr_mem_req_off", 32'(mem_req),   0);
    check("wr_rdata_kept",  32'(dma_rdata), 0);
    dma_req = 0;
    tick();
    check("wr_done_once", 32'(dma_done), 0);

    // continuous contention, CPU_BURST=4
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0A00;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0B00;
    for (int i = 0; i < 10; i++) begin
      serve(16'h5000 + 16'(i), who);
      check($sformatf("burst_grant_%0d", i), 32'(who), 32'(burst_seq[i]));
    end
    cpu_req = 0; dma_req = 0;
    tick();

    // reset in BUSY after streak has built up to 3
    cpu_req = 1; dma_req = 1;
    serve(16'h1111, who);
    check("pre_rst_grant0", 32'(who), 32'(C));
    serve(16'h2222, who);
    check("pre_rst_grant1", 32'(who), 32'(C));
    tick();
    check("pre_rst_busy", 32'(mem_req), 1);
    rst = 1; cpu_req = 0; dma_req = 0;
    tick();
    check("midrst_mem_req",   32'(mem_req),   0);
    check("midrst_cpu_done",  32'(cpu_done),  0);
    check("midrst_dma_done",  32'(dma_done),  0);
    check("midrst_cpu_rdata", 32'(cpu_rdata), 0);
    rst = 0;
    tick();
    check("postrst_no_done", 32'({dma_done, cpu_done, mem_req}), 0);
    tick();
    check("postrst_idle", 32'({dma_done, cpu_done, mem_req}), 0);

    // simultaneous requests after reset: streak restarted from 0
    cpu_req = 1; dma_req = 1;
    for (int i = 0; i < 5; i++) begin
      serve(16'h3000 + 16'(i), who);
      check($sformatf("postrst_grant_%0d", i), 32'(who), 32'(burst_seq[i]));
    end
    check("postrst_dma_rdata", 32'(dma_rdata), 32'h3004);
    check("postrst_cpu_rdata", 32'(cpu_rdata), 32'h3003);
    cpu_req = 0; dma_req = 0;
    tick();

    // unanswered CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0033;
    tick();
`ifdef ARB_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_done) break;
      if (mem_req) cnt++;
      tick();
    end
    check("to_req_cycles", 32'(cnt),       8);
    check("to_cpu_done",   32'(cpu_done),  1);
    check("to_err",        32'(err),       1);
    check("to_cpu_rdata",  32'(cpu_rdata), 32'hFFFF);
    cpu_req = 0;
    tick();
    check("to_err_once", 32'(err), 0);
`else
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req && !err && !cpu_done) cnt++;
      tick();
    end
    check("noto_req_held", 32'(cnt), 20);
    mem_ack = 1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 0;
    check("noto_cpu_done",  32'(cpu_done),  1);
    check("noto_err",       32'(err),       0);
    check("noto_cpu_rdata", 32'(cpu_rdata), 32'h7777);
    cpu_req = 0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
